// File: rtl/imm_ext_pipe.sv
// Registered immediate extender for the decode->execute boundary.
// Five extension modes, valid/ready on both sides, 2-entry skid for full throughput.

// state | meaning
// EMPTY | no entry held, imm_out not valid
// ONE   | main register holds the oldest entry, skid empty
// FULL  | main and skid both hold entries, input stalled
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm_in,
   input  logic [2:0]       ext_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] imm_out,
   output logic             out_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int PAD = OUT_W - IN_W;

   // Encoding is {main valid, skid valid}; 01 never occurs.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t           state;
   logic [OUT_W-1:0] m_data, s_data;
   logic             m_err, s_err;
   logic [OUT_W-1:0] ext_data, zero_ext, sign_ext;
   logic             ext_err;
   logic             accept, issue;

   always_comb begin
      zero_ext = {{PAD{1'b0}}, imm_in};
      sign_ext = {{PAD{imm_in[IN_W-1]}}, imm_in};
      ext_data = '0;
      ext_err  = 1'b0;
      case (ext_op)
         3'b000:  ext_data = zero_ext;
         3'b001:  ext_data = sign_ext;
         3'b010:  ext_data = {imm_in, {PAD{1'b0}}};
         3'b011:  ext_data = sign_ext << 2;
         3'b100:  ext_data = zero_ext << 2;
         default: ext_err  = 1'b1;
      endcase
   end

   // in_ready depends only on registered state, never on out_ready.
   assign in_ready  = ~state[0];
   assign out_valid = state[1];
   assign imm_out   = m_data;
   assign out_err   = m_err;
   assign accept    = in_valid & in_ready;
   assign issue     = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         m_data     <= '0;
         m_err      <= 1'b0;
         s_data     <= '0;
         s_err      <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  m_data <= ext_data;
                  m_err  <= ext_err;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && issue) begin
                  m_data <= ext_data;
                  m_err  <= ext_err;
               end else if (accept) begin
                  s_data <= ext_data;
                  s_err  <= ext_err;
                  state  <= FULL;
               end else if (issue) begin
                  state  <= EMPTY;
               end
            end
            FULL: begin
               if (issue) begin
                  m_data <= s_data;
                  m_err  <= s_err;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase

         if (accept && ext_err) begin
            err_sticky <= 1'b1;
            if (!(&err_cnt))
               err_cnt <= err_cnt + CNT_W'(1'b1);
         end
      end
   end

endmodule
